sa_stream_driver: RTL
=====================

Name: sa_stream_driver

Overview:
- Host-side front end for `systolic_array`.
- Host loads full N_SIZE x N_SIZE matrices A and B element by element, then pulses `start`.
- Block streams column k of A and row k of B to the array for N_SIZE consecutive beats.
- It then captures the N_SIZE result rows of C from the array's output side into a buffer the host can read at random.
- Sits between the host register interface and `systolic_array`; drives its inputs and consumes its outputs.

Parameters:
- DATAWIDTH, 16, signed element width of A and B.
- N_SIZE, 4, matrix dimension and array size.
- TIMEOUT, 64, max cycles in WAIT before flagging error (must be >= 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write one element of A or B.
- wr_sel  in  1  0 = A, 1 = B.
- wr_row  in  $clog2(N_SIZE)  element row index.
- wr_col  in  $clog2(N_SIZE)  element column index.
- wr_data  in  DATAWIDTH signed  element value.
- start  in  1  single-cycle request to run a multiply.
- busy  out  1  high in STREAM, WAIT and COLLECT.
- done  out  1  high in DONE (results valid).
- error  out  1  sticky timeout flag; cleared by next accepted start.
- rd_row  in  $clog2(N_SIZE)  result row index.
- rd_col  in  $clog2(N_SIZE)  result column index.
- rd_data  out  2*DATAWIDTH signed  combinational C[rd_row][rd_col] from result buffer.
- sa_valid_in  out  1  to array valid_in.
- sa_matrix_a_in  out  [N_SIZE-1:0] x DATAWIDTH signed  to array matrix_a_in.
- sa_matrix_b_in  out  [N_SIZE-1:0] x DATAWIDTH signed  to array matrix_b_in.
- sa_valid_out  in  1  from array valid_out.
- sa_matrix_c_out  in  [N_SIZE-1:0] x 2*DATAWIDTH signed  from array matrix_c_out.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; sa_valid_in, busy, done and error = 0.
  - sa_matrix_a_in and sa_matrix_b_in = 0.
  - A, B and C buffers cleared to 0; beat and row counters = 0.
- States:
  - IDLE: accepts writes and start.
  - STREAM: drives N_SIZE beats to the array.
  - WAIT: waits for the first sa_valid_out.
  - COLLECT: captures result rows.
  - DONE: accepts writes and start; done = 1.
- Writes:
  - Accepted only in IDLE or DONE; the element is updated at the clock edge.
  - Ignored in busy states.
  - A write in the same cycle as an accepted start is dropped.
- Start:
  - Sampled high in IDLE or DONE at edge E0: clears error and done, enters STREAM.
  - Ignored while busy.
- STREAM (registered outputs):
  - Beat k (k = 0..N_SIZE-1) is presented in the cycle after edge E0+k.
  - sa_matrix_a_in[r] = A[r][k]; sa_matrix_b_in[c] = B[k][c]; sa_valid_in = 1.
  - After edge E0+N_SIZE: sa_valid_in = 0, data outputs = 0, state = WAIT.
- WAIT:
  - sa_valid_out is ignored in every state except WAIT and COLLECT.
  - Timeout counter runs from 0; if it reaches TIMEOUT with no sa_valid_out: error = 1, state = IDLE, done stays 0.
- COLLECT:
  - The first cycle with sa_valid_out = 1 in WAIT captures row 0.
  - Rows 1..N_SIZE-1 are captured on the following N_SIZE-1 consecutive edges, regardless of sa_valid_out.
  - Capture mapping: C[i][j] <= sa_matrix_c_out[N_SIZE-1-j] (element 0 of the bus is the last column).
  - After row N_SIZE-1: state = DONE.
- DONE: done held high until the next accepted start; results are held.
- Reads: allowed in every state; rd_data shows current buffer contents, including partially updated rows during COLLECT.
- Arithmetic: no arithmetic in this block; values pass through unmodified, sign preserved.
- Reset mid-operation: aborts immediately; the next run requires a reload and start.
- Indices are always < N_SIZE by contract; behaviour for out-of-range indices is undefined.

Test Plan:
- Reset, then load A rows (4,34,0,23), (6,4,32,65), (6,4,3,5), (6,7,8,4) and B rows (3,2,454,76), (54,7,856,0), (0,0,0,56), (34,3,3,3); pulse start -> beat 0 shows a = (4,6,6,6), b = (3,2,454,76); beat 3 shows a = (23,65,5,4), b = (34,3,3,3); sa_valid_in high exactly 4 cycles.
- Same stimulus with `systolic_array` attached -> done = 1; rd C[0][0] = 2630, C[0][2] = 30989, C[3][3] = 6*76+8*56+4*3 = 916.
- Array model drives sa_valid_out for 1 cycle with sa_matrix_c_out = (-96,10,20,30) (index 0 first), then rows of 0 -> C[0][0] = 30, C[0][3] = -96 with sign intact; rows 1..3 read 0.
- No sa_valid_out after streaming -> error = 1 exactly 64 cycles after WAIT entry; state IDLE; busy = 0, done = 0; next start clears error.
- wr_en and start pulsed during STREAM, plus wr_en and start in the same cycle in IDLE -> buffer unchanged in both cases; stream unaffected; second start not queued.
- Assert rst_n = 0 during beat 2 -> sa_valid_in = 0 and outputs = 0 immediately; busy = 0; later rd_data = 0.

Source files
------------

// File: rtl/sa_stream_driver.sv
// ============================================================================
// Module   : sa_stream_driver
// Purpose  : Host front end for systolic_array. It buffers A and B, streams
//            the column/row beats, then captures the result rows of C.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_stream_driver #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wr_en,
  input  logic                                     wr_sel,
  input  logic        [$clog2(N_SIZE)-1:0]         wr_row,
  input  logic        [$clog2(N_SIZE)-1:0]         wr_col,
  input  logic signed [DATAWIDTH-1:0]              wr_data,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  input  logic        [$clog2(N_SIZE)-1:0]         rd_row,
  input  logic        [$clog2(N_SIZE)-1:0]         rd_col,
  output logic signed [2*DATAWIDTH-1:0]            rd_data,
  output logic                                     sa_valid_in,
  output logic signed [N_SIZE-1:0][DATAWIDTH-1:0]  sa_matrix_a_in,
  output logic signed [N_SIZE-1:0][DATAWIDTH-1:0]  sa_matrix_b_in,
  input  logic                                     sa_valid_out,
  input  logic signed [N_SIZE-1:0][2*DATAWIDTH-1:0] sa_matrix_c_out
);

  localparam int IW = $clog2(N_SIZE);
  localparam int BW = $clog2(N_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STREAM  = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [DATAWIDTH-1:0]   r_a [N_SIZE][N_SIZE];
  logic signed [DATAWIDTH-1:0]   r_b [N_SIZE][N_SIZE];
  logic signed [2*DATAWIDTH-1:0] r_c [N_SIZE][N_SIZE];

  logic [BW-1:0] r_beat;
  logic [IW-1:0] r_row;
  logic [TW-1:0] r_tmo;
  logic          r_error;
  logic          r_valid;

  logic w_accept;
  logic w_start_acc;
  logic w_wr_acc;
  logic w_beat_end;
  logic w_tmo_last;
  logic w_row_last;

  assign w_accept    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_acc = w_accept && start;
  // A write coinciding with an accepted start is dropped.
  assign w_wr_acc    = w_accept && wr_en && !start;
  assign w_beat_end  = (r_beat == BW'(N_SIZE));
  assign w_tmo_last  = (r_tmo == TW'(TIMEOUT - 1));
  assign w_row_last  = (r_row == IW'(N_SIZE - 1));

  assign error       = r_error;
  assign sa_valid_in = r_valid;
  assign rd_data     = r_c[rd_row][rd_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nx = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (w_beat_end) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (sa_valid_out)    w_state_nx = S_COLLECT;
        else if (w_tmo_last) w_state_nx = S_IDLE;
      end
      S_COLLECT: begin
        busy = 1'b1;
        if (w_row_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_nx = S_STREAM;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SIZE; i++) begin
        for (int j = 0; j < N_SIZE; j++) begin
          r_a[IW'(i)][IW'(j)] <= '0;
          r_b[IW'(i)][IW'(j)] <= '0;
          r_c[IW'(i)][IW'(j)] <= '0;
        end
      end
      sa_matrix_a_in <= '0;
      sa_matrix_b_in <= '0;
      r_valid        <= 1'b0;
      r_error        <= 1'b0;
      r_beat         <= '0;
      r_row          <= '0;
      r_tmo          <= '0;
    end else begin
      if (w_wr_acc) begin
        if (wr_sel) r_b[wr_row][wr_col] <= wr_data;
        else        r_a[wr_row][wr_col] <= wr_data;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_acc) begin
            r_error <= 1'b0;
            r_valid <= 1'b1;
            for (int r = 0; r < N_SIZE; r++) begin
              sa_matrix_a_in[IW'(r)] <= r_a[IW'(r)][IW'(0)];
              sa_matrix_b_in[IW'(r)] <= r_b[IW'(0)][IW'(r)];
            end
            r_beat <= BW'(1);
            r_row  <= '0;
            r_tmo  <= '0;
          end
        end
        S_STREAM: begin
          if (w_beat_end) begin
            r_valid        <= 1'b0;
            sa_matrix_a_in <= '0;
            sa_matrix_b_in <= '0;
            r_tmo          <= '0;
          end else begin
            for (int r = 0; r < N_SIZE; r++) begin
              sa_matrix_a_in[IW'(r)] <= r_a[IW'(r)][r_beat[IW-1:0]];
              sa_matrix_b_in[IW'(r)] <= r_b[r_beat[IW-1:0]][IW'(r)];
            end
            r_beat <= r_beat + BW'(1);
          end
        end
        S_WAIT: begin
          if (sa_valid_out) begin
            // Bus element 0 carries the last column of the row.
            for (int j = 0; j < N_SIZE; j++) begin
              r_c[IW'(0)][IW'(j)] <= sa_matrix_c_out[IW'(N_SIZE - 1 - j)];
            end
            r_row <= IW'(1);
          end else if (w_tmo_last) begin
            r_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_COLLECT: begin
          for (int j = 0; j < N_SIZE; j++) begin
            r_c[r_row][IW'(j)] <= sa_matrix_c_out[IW'(N_SIZE - 1 - j)];
          end
          r_row <= r_row + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire
